// File: rtl/spi_nor_pkg.sv
// Shared definitions for the SPI NOR flash responder.
// Contents: opcodes, status register bit indices, command FSM state encoding,
// and an opcode decoder.
package spi_nor_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;

  localparam int unsigned SR_WIP = 0;
  localparam int unsigned SR_WEL = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_STAT,
    ST_ID,
    ST_RD,
    ST_PRG,
    ST_WAIT,
    ST_IGNORE
  } state_e;

  // Map the first byte of a command to the state that handles the rest of it.
  // While busy, only status reads are honoured.
  function automatic state_e decode_op(input logic [7:0] op, input logic wip);
    state_e st;
    case (op)
      OP_WREN, OP_WRDI:      st = ST_WAIT;
      OP_RDSR:               st = ST_STAT;
      OP_RDID:               st = ST_ID;
      OP_READ, OP_PP, OP_SE: st = ST_ADDR;
      default:               st = ST_IGNORE;
    endcase
    if (wip && (op != OP_RDSR)) st = ST_IGNORE;
    return st;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the oversampled SPI pins into the system clock domain and
// produces single-cycle event pulses.
// Ports:
//   clk_i, rst_ni    system clock, async active-low reset
//   sclk_i, css_i    raw SPI clock and chip select
//   mosi_i[7:0]      raw data byte
//   rise_o, fall_o   s_clk rising (only while selected) / falling event
//   css_high_o       synchronised chip select level
//   css_rise_o       chip select deassertion event
//   mosi_o[7:0]      data byte aligned with rise_o
module spi_edge_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sclk_i,
  input  logic       css_i,
  input  logic [7:0] mosi_i,
  output logic       rise_o,
  output logic       fall_o,
  output logic       css_high_o,
  output logic       css_rise_o,
  output logic [7:0] mosi_o
);

  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       css_s1_q, css_s2_q, css_s3_q;
  logic [7:0] mosi_s1_q, mosi_s2_q, mosi_q;
  logic       rise_q, fall_q, css_high_q, css_rise_q;

  // Synchroniser chains; the third stage holds the previous value for edge detection.
  // Data takes the same number of stages so it lines up with the rise pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      css_s1_q   <= 1'b1;
      css_s2_q   <= 1'b1;
      css_s3_q   <= 1'b1;
      mosi_s1_q  <= 8'h00;
      mosi_s2_q  <= 8'h00;
      mosi_q     <= 8'h00;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      css_high_q <= 1'b1;
      css_rise_q <= 1'b0;
    end else begin
      sclk_s1_q  <= sclk_i;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      css_s1_q   <= css_i;
      css_s2_q   <= css_s1_q;
      css_s3_q   <= css_s2_q;
      mosi_s1_q  <= mosi_i;
      mosi_s2_q  <= mosi_s1_q;
      mosi_q     <= mosi_s2_q;
      rise_q     <= sclk_s2_q & ~sclk_s3_q & ~css_s2_q;
      fall_q     <= ~sclk_s2_q & sclk_s3_q;
      css_high_q <= css_s2_q;
      css_rise_q <= css_s2_q & ~css_s3_q;
    end
  end

  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign css_high_o = css_high_q;
  assign css_rise_o = css_rise_q;
  assign mosi_o     = mosi_q;

endmodule

// File: rtl/spi_norflash_responder.sv
// Device end of a byte-wide SPI NOR flash link: command decode, status/ID/read
// responses, page program and sector erase with write-in-progress timing.
// Ports:
//   p_clk, p_reset_n  system clock, async active-low reset
//   s_clk, s_css      SPI clock (sampled as data) and active-low chip select
//   s_mosi[7:0]       command/address/data byte, taken on s_clk rise
//   s_miso[7:0]       response byte, updated after s_clk fall
module spi_norflash_responder
  import spi_nor_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned PAGE_BYTES   = 256,
  parameter int unsigned SECTOR_BYTES = 1024,
  parameter int unsigned PROG_CYCLES  = 64,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
  input  logic       p_clk,
  input  logic       p_reset_n,
  input  logic       s_clk,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PAGE_W = $clog2(PAGE_BYTES);
  localparam int unsigned SECT_W = $clog2(SECTOR_BYTES);
  localparam int unsigned TMR_W  = $clog2(PROG_CYCLES + 1);

  logic       rise, fall, css_high, css_rise;
  logic [7:0] mosi;

  spi_edge_sync u_sync (
    .clk_i      (p_clk),
    .rst_ni     (p_reset_n),
    .sclk_i     (s_clk),
    .css_i      (s_css),
    .mosi_i     (s_mosi),
    .rise_o     (rise),
    .fall_o     (fall),
    .css_high_o (css_high),
    .css_rise_o (css_rise),
    .mosi_o     (mosi)
  );

  state_e                     state_q, state_d;
  logic [7:0]                 miso_q, miso_d;
  logic [7:0]                 cmd_q, cmd_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       prg_any_q, prg_any_d;
  logic                       wel_q, wel_d;
  logic                       wip_q, wip_d;
  logic                       erasing_q, erasing_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic [ADDR_W-SECT_W-1:0]   sect_q, sect_d;
  logic [SECT_W-1:0]          eoff_q, eoff_d;
  logic [7:0]                 sr_c;

  // Array stores inverted bytes so zero-initialised storage reads as erased (FF).
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  assign mem_addr  = erasing_q ? {sect_q, eoff_q} : addr_q;
  assign mem_rdata = mem_q[mem_addr];

  always_ff @(posedge p_clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // State register.
  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; deselect always returns to idle and drops partial commands.
  always_comb begin
    state_d = state_q;
    if (css_high) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD:  if (rise) state_d = decode_op(mosi, wip_q);
        ST_ADDR: begin
          if (rise && (cnt_q == 2'd2)) begin
            case (cmd_q)
              OP_READ: state_d = ST_RD;
              OP_PP:   state_d = ST_PRG;
              default: state_d = ST_WAIT;
            endcase
          end
        end
        // A byte beyond the expected length invalidates WREN/WRDI/SE.
        ST_WAIT: if (rise) state_d = ST_IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sr_c         = 8'h00;
    sr_c[SR_WEL] = wel_q;
    sr_c[SR_WIP] = wip_q;
  end

  // Output and datapath logic.
  always_comb begin
    miso_d    = miso_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    prg_any_d = prg_any_q;
    wel_d     = wel_q;
    wip_d     = wip_q;
    erasing_d = erasing_q;
    tmr_d     = tmr_q;
    sect_d    = sect_q;
    eoff_d    = eoff_q;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;

    // Busy engines: sector erase sweeps one byte per cycle, program just times out.
    if (erasing_q) begin
      mem_we    = 1'b1;
      mem_wdata = 8'h00;
      eoff_d    = eoff_q + SECT_W'(1);
      if (&eoff_q) begin
        erasing_d = 1'b0;
        wip_d     = 1'b0;
        wel_d     = 1'b0;
      end
    end else if (wip_q) begin
      if (tmr_q == '0) begin
        wip_d = 1'b0;
        wel_d = 1'b0;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end

    if (css_high) begin
      miso_d = 8'hFF;
      if (css_rise) begin
        if (state_q == ST_WAIT) begin
          case (cmd_q)
            OP_WREN: wel_d = 1'b1;
            OP_WRDI: wel_d = 1'b0;
            OP_SE: begin
              if (wel_q) begin
                wip_d     = 1'b1;
                erasing_d = 1'b1;
                sect_d    = addr_q[ADDR_W-1:SECT_W];
                eoff_d    = '0;
              end
            end
            default: ;
          endcase
        end else if ((state_q == ST_PRG) && prg_any_q && wel_q) begin
          wip_d = 1'b1;
          tmr_d = TMR_W'(PROG_CYCLES - 1);
        end
      end
    end else begin
      case (state_q)
        ST_CMD: begin
          if (rise) begin
            cmd_d     = mosi;
            cnt_d     = 2'd0;
            prg_any_d = 1'b0;
          end
        end
        ST_ADDR: begin
          // Upper address bits alias away as they shift out of the register.
          if (rise) begin
            addr_d = ADDR_W'({addr_q, mosi});
            cnt_d  = cnt_q + 2'd1;
          end
        end
        ST_STAT: if (fall) miso_d = sr_c;
        ST_ID: begin
          if (fall) begin
            case (cnt_q)
              2'd0:    miso_d = JEDEC_ID[23:16];
              2'd1:    miso_d = JEDEC_ID[15:8];
              2'd2:    miso_d = JEDEC_ID[7:0];
              default: miso_d = 8'h00;
            endcase
            if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
          end
        end
        ST_RD: begin
          if (fall) begin
            miso_d = ~mem_rdata;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        ST_PRG: begin
          if (fall) miso_d = 8'hFF;
          if (rise) begin
            prg_any_d = 1'b1;
            // NOR program clears bits only: stored = ~(old & byte).
            if (wel_q) begin
              mem_we    = 1'b1;
              mem_wdata = mem_rdata | ~mosi;
            end
            addr_d[PAGE_W-1:0] = addr_q[PAGE_W-1:0] + PAGE_W'(1);
          end
        end
        default: if (fall) miso_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      miso_q    <= 8'hFF;
      cmd_q     <= 8'h00;
      addr_q    <= '0;
      cnt_q     <= 2'd0;
      prg_any_q <= 1'b0;
      wel_q     <= 1'b0;
      wip_q     <= 1'b0;
      erasing_q <= 1'b0;
      tmr_q     <= '0;
      sect_q    <= '0;
      eoff_q    <= '0;
    end else begin
      miso_q    <= miso_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      prg_any_q <= prg_any_d;
      wel_q     <= wel_d;
      wip_q     <= wip_d;
      erasing_q <= erasing_d;
      tmr_q     <= tmr_d;
      sect_q    <= sect_d;
      eoff_q    <= eoff_d;
    end
  end

  assign s_miso = miso_q;

endmodule

// File: tb/tb_spi_norflash_responder.sv
// Directed plus randomized bench for spi_norflash_responder against a
// byte-array model of the flash (contents, WEL, busy).
module tb_spi_norflash_responder;

  logic       p_clk = 1'b0;
  logic       p_reset_n;
  logic       s_clk;
  logic       s_css;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [4096];
  bit         wel_m;
  bit         busy_m;
  logic [7:0] tx[$];
  logic [7:0] rsp[$];
  logic [7:0] pd[$];

  always #5 p_clk = ~p_clk;

  spi_norflash_responder dut (
    .p_clk     (p_clk),
    .p_reset_n (p_reset_n),
    .s_clk     (s_clk),
    .s_css     (s_css),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  // One byte-wide SPI cycle; the returned byte is what the fall of this cycle drove.
  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    s_mosi = b;
    #40 s_clk = 1'b1;
    #80 s_clk = 1'b0;
    #80 r = s_miso;
  endtask

  task automatic run_txn();
    logic [7:0] r;
    rsp.delete();
    s_css = 1'b0;
    #80;
    foreach (tx[i]) begin
      xfer(tx[i], r);
      rsp.push_back(r);
    end
    #40 s_css = 1'b1;
    #120;
  endtask

  task automatic push_addr(input logic [23:0] a);
    tx.push_back(a[23:16]);
    tx.push_back(a[15:8]);
    tx.push_back(a[7:0]);
  endtask

  task automatic op1(input logic [7:0] op);
    tx.delete();
    tx.push_back(op);
    run_txn();
  endtask

  task automatic wren();
    op1(8'h06);
    if (!busy_m) wel_m = 1'b1;
  endtask

  task automatic check_sr(input string tag);
    logic [7:0] exp;
    tx.delete();
    tx.push_back(8'h05);
    tx.push_back(8'($urandom));
    run_txn();
    exp = {6'b0, wel_m, busy_m};
    check(tag, rsp[0], exp);
    check(tag, rsp[1], exp);
  endtask

  task automatic pp(input logic [23:0] a);
    int unsigned a12;
    int unsigned idx;
    tx.delete();
    tx.push_back(8'h02);
    push_addr(a);
    foreach (pd[i]) tx.push_back(pd[i]);
    run_txn();
    if (wel_m && !busy_m && (pd.size() > 0)) begin
      a12 = int'(a) & 32'hFFF;
      foreach (pd[i]) begin
        idx = (a12 & 32'hF00) | ((a12 + i) & 32'hFF);
        mem_m[idx] = mem_m[idx] & pd[i];
      end
      busy_m = 1'b1;
    end
  endtask

  task automatic se(input logic [23:0] a, input int naddr);
    int unsigned base;
    tx.delete();
    tx.push_back(8'h20);
    for (int i = 0; i < naddr; i++) begin
      if (i == 0) tx.push_back(a[23:16]);
      else if (i == 1) tx.push_back(a[15:8]);
      else if (i == 2) tx.push_back(a[7:0]);
      else tx.push_back(8'($urandom));
    end
    run_txn();
    if ((naddr == 3) && wel_m && !busy_m) begin
      base = int'(a) & 32'hC00;
      for (int i = 0; i < 1024; i++) mem_m[base + i] = 8'hFF;
      busy_m = 1'b1;
    end
  endtask

  task automatic rd_check(input string tag, input logic [23:0] a, input int n);
    int unsigned a12;
    tx.delete();
    tx.push_back(8'h03);
    push_addr(a);
    for (int i = 1; i < n; i++) tx.push_back(8'($urandom));
    run_txn();
    a12 = int'(a) & 32'hFFF;
    for (int i = 0; i < n; i++)
      check(tag, rsp[3 + i], busy_m ? 8'hFF : mem_m[(a12 + i) & 32'hFFF]);
  endtask

  task automatic wait_done(input int cycles);
    #(cycles * 10);
    if (busy_m) begin
      busy_m = 1'b0;
      wel_m  = 1'b0;
    end
  endtask

  task automatic prog1(input logic [23:0] a, input logic [7:0] d);
    wren();
    pd.delete();
    pd.push_back(d);
    pp(a);
    wait_done(100);
  endtask

  initial begin
    s_css = 1'b1;
    s_clk = 1'b0;
    s_mosi = 8'h00;
    p_reset_n = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 8'hFF;
    wel_m = 1'b0;
    busy_m = 1'b0;
    #32 p_reset_n = 1'b1;
    #30;
    check("reset_miso", s_miso, 8'hFF);

    // JEDEC ID, then zeros
    tx.delete();
    tx.push_back(8'h9F);
    repeat (4) tx.push_back(8'($urandom));
    run_txn();
    check("rdid0", rsp[0], 8'hEF);
    check("rdid1", rsp[1], 8'h40);
    check("rdid2", rsp[2], 8'h18);
    check("rdid3", rsp[3], 8'h00);
    check("rdid4", rsp[4], 8'h00);
    check_sr("sr_reset");

    wren();
    check_sr("sr_wren");
    op1(8'h04);
    wel_m = 1'b0;
    check_sr("sr_wrdi");

    // Page program and read-back
    wren();
    pd = '{8'hA5, 8'h3C};
    pp(24'h000010);
    check_sr("sr_pp_busy");
    wait_done(100);
    check_sr("sr_pp_done");
    rd_check("rd_pp", 24'h000010, 3);

    // Program ANDs into existing data; program without WEL is inert
    wren();
    pd = '{8'h0F};
    pp(24'h000010);
    wait_done(100);
    rd_check("rd_and", 24'h000010, 1);
    check("rd_and_val", rsp[3], 8'h05);
    pd = '{8'hF0};
    pp(24'h000010);
    check_sr("sr_pp_nowel");
    rd_check("rd_nowel", 24'h000010, 1);

    // Page wrap during program, array wrap during read
    wren();
    pd = '{8'h11, 8'h22};
    pp(24'h0000FF);
    wait_done(100);
    rd_check("rd_pg_ff", 24'h0000FF, 1);
    rd_check("rd_pg_00", 24'h000000, 1);
    rd_check("rd_wrap", 24'h000FFF, 2);

    // Sector erase with neighbours outside the sector
    prog1(24'h0003FF, 8'($urandom_range(0, 254)));
    prog1(24'h000400, 8'($urandom_range(0, 254)));
    prog1(24'h0007FF, 8'($urandom_range(0, 254)));
    prog1(24'h000800, 8'($urandom_range(0, 254)));
    wren();
    se(24'h000400, 3);
    check_sr("sr_se_busy");
    rd_check("rd_during_wip", 24'h000400, 2);
    wren();
    check_sr("sr_wren_during_wip");
    wait_done(1100);
    check_sr("sr_se_done");
    rd_check("rd_se_lo", 24'h0003FE, 3);
    rd_check("rd_se_hi", 24'h0007FE, 3);
    repeat (6) rd_check("rd_se_rnd", 24'(24'h000400 + $urandom_range(0, 1023)), 1);

    // Erase with wrong address length does nothing; reset aborts an erase
    prog1(24'h000500, 8'h5A);
    wren();
    se(24'h000400, 2);
    check_sr("sr_se_short");
    se(24'h000400, 4);
    check_sr("sr_se_long");
    rd_check("rd_se_kept", 24'h000500, 1);
    se(24'h000400, 3);
    check_sr("sr_se_abort_busy");
    p_reset_n = 1'b0;
    #30 p_reset_n = 1'b1;
    #30;
    busy_m = 1'b0;
    wel_m = 1'b0;
    check("reset_mid_miso", s_miso, 8'hFF);
    check_sr("sr_after_reset");
    tx.delete();
    tx.push_back(8'h03);
    push_addr(24'h000500);
    run_txn();
    checks++;
    assert (!$isunknown(rsp[3])) else begin
      errors++;
      $error("FAIL rd_no_x: observed %02h expected known value", rsp[3]);
    end
    wren();
    se(24'h000400, 3);
    wait_done(1100);
    rd_check("rd_reerase", 24'h000500, 1);

    // Random programs, sometimes without write enable, at aliased addresses
    repeat (10) begin
      logic [23:0] a;
      int          n;
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      if ($urandom_range(0, 3) != 0) wren();
      pd.delete();
      repeat (n) pd.push_back(8'($urandom));
      pp(a);
      check_sr("sr_rnd");
      wait_done(100);
      rd_check("rd_rnd", a, n + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
